// File: rtl/ex_stage_pipe.sv
// Execute stage with built-in EX/MEM pipeline register.
// Covers operand forwarding, the ALU, the valid/stall/flush handshake and an
// iterative shift-add multiplier that retires MUL_R multiplier bits per cycle.
// While a multiply runs, stall_out holds the front end.
module ex_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int REGW  = 5,
  parameter int MEM_W = 3,
  parameter int WB_W  = 2,
  parameter int MUL_R = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             stall_out,
  input  logic             stall_in,
  input  logic             flush,
  input  logic [REGW-1:0]  rs,
  input  logic [REGW-1:0]  rt,
  input  logic [REGW-1:0]  rd,
  input  logic [XLEN-1:0]  read_d1,
  input  logic [XLEN-1:0]  read_d2,
  input  logic [XLEN-1:0]  se,
  input  logic             reg_dst,
  input  logic             alu_src,
  input  logic [3:0]       alu_op,
  input  logic [MEM_W-1:0] MEM,
  input  logic [WB_W-1:0]  WB,
  input  logic [REGW-1:0]  EXMEMRegRd,
  input  logic [REGW-1:0]  MEMWBRegRd,
  input  logic             EXMEM_RegWrite,
  input  logic             MEMWB_RegWrite,
  input  logic [XLEN-1:0]  ALU_result,
  input  logic [XLEN-1:0]  WB_data,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             out_valid,
  output logic [XLEN-1:0]  result_out,
  output logic [XLEN-1:0]  read_d2_out,
  output logic             zero,
  output logic [REGW-1:0]  write_register_out,
  output logic [MEM_W-1:0] MEM_out,
  output logic [WB_W-1:0]  WB_out
);

  localparam int N   = XLEN / MUL_R;
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_NOR = 4'd12;

  typedef enum logic [0:0] {S_RUN = 1'b0, S_MUL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  bf_hold_q, bf_hold_d;
  logic [REGW-1:0]  wr_hold_q, wr_hold_d;
  logic [MEM_W-1:0] mem_hold_q, mem_hold_d;
  logic [WB_W-1:0]  wb_hold_q, wb_hold_d;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [XLEN-1:0]  rd2_q, rd2_d;
  logic             zero_q, zero_d;
  logic [REGW-1:0]  wreg_q, wreg_d;
  logic [MEM_W-1:0] mem_q, mem_d;
  logic [WB_W-1:0]  wb_q, wb_d;

  logic [XLEN-1:0]  op_a_s, op_bf_s, op_b_s, alu_res_s;
  logic [XLEN-1:0]  digit_s, step_sum_s;
  logic [REGW-1:0]  wreg_sel_s;
  logic             accept_s;

  // Forward selects: EX/MEM has priority over MEM/WB; register 0 never forwards
  always_comb begin
    ForwardA = 2'd0;
    ForwardB = 2'd0;
    if (EXMEM_RegWrite && (EXMEMRegRd != {REGW{1'b0}}) && (EXMEMRegRd == rs)) begin
      ForwardA = 2'd2;
    end else if (MEMWB_RegWrite && (MEMWBRegRd != {REGW{1'b0}}) && (MEMWBRegRd == rs)) begin
      ForwardA = 2'd1;
    end else begin
      ForwardA = 2'd0;
    end
    if (EXMEM_RegWrite && (EXMEMRegRd != {REGW{1'b0}}) && (EXMEMRegRd == rt)) begin
      ForwardB = 2'd2;
    end else if (MEMWB_RegWrite && (MEMWBRegRd != {REGW{1'b0}}) && (MEMWBRegRd == rt)) begin
      ForwardB = 2'd1;
    end else begin
      ForwardB = 2'd0;
    end
  end

  // Operand muxing and single-cycle ALU
  always_comb begin
    op_a_s    = read_d1;
    op_bf_s   = read_d2;
    alu_res_s = {XLEN{1'b0}};
    case (ForwardA)
      2'd1:    op_a_s = WB_data;
      2'd2:    op_a_s = ALU_result;
      default: op_a_s = read_d1;
    endcase
    case (ForwardB)
      2'd1:    op_bf_s = WB_data;
      2'd2:    op_bf_s = ALU_result;
      default: op_bf_s = read_d2;
    endcase
    op_b_s     = alu_src ? se : op_bf_s;
    wreg_sel_s = reg_dst ? rd : rt;
    case (alu_op)
      OP_AND:  alu_res_s = op_a_s & op_b_s;
      OP_OR:   alu_res_s = op_a_s | op_b_s;
      OP_ADD:  alu_res_s = op_a_s + op_b_s;
      OP_SUB:  alu_res_s = op_a_s - op_b_s;
      OP_SLL:  alu_res_s = op_a_s << op_b_s[SHW-1:0];
      OP_SRL:  alu_res_s = op_a_s >> op_b_s[SHW-1:0];
      OP_SLT:  alu_res_s = ($signed(op_a_s) < $signed(op_b_s)) ? {{(XLEN-1){1'b0}}, 1'b1}
                                                               : {XLEN{1'b0}};
      OP_NOR:  alu_res_s = ~(op_a_s | op_b_s);
      default: alu_res_s = {XLEN{1'b0}};
    endcase
  end

  // One shift-add step: accumulator plus multiplicand times the low multiplier digit
  always_comb begin
    digit_s              = {XLEN{1'b0}};
    digit_s[MUL_R-1:0]   = mplier_q[MUL_R-1:0];
    step_sum_s           = acc_q + (mcand_q * digit_s);
  end

  assign accept_s  = (state_q == S_RUN) && in_valid && !stall_in && !flush;
  assign stall_out = (state_q == S_MUL);

  // Next-state, multiplier datapath and EX/MEM register load/bubble/hold
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    bf_hold_d   = bf_hold_q;
    wr_hold_d   = wr_hold_q;
    mem_hold_d  = mem_hold_q;
    wb_hold_d   = wb_hold_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    rd2_d       = rd2_q;
    zero_d      = zero_q;
    wreg_d      = wreg_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    if (flush) begin
      // Squash: bubble out and abandon any multiply in progress
      state_d     = S_RUN;
      cnt_d       = {CW{1'b0}};
      acc_d       = {XLEN{1'b0}};
      out_valid_d = 1'b0;
      mem_d       = {MEM_W{1'b0}};
      wb_d        = {WB_W{1'b0}};
    end else if (state_q == S_RUN) begin
      if (accept_s && (alu_op == OP_MUL)) begin
        // Capture everything now so later forwarding changes cannot disturb it
        state_d     = S_MUL;
        cnt_d       = {CW{1'b0}};
        acc_d       = {XLEN{1'b0}};
        mcand_d     = op_a_s;
        mplier_d    = op_b_s;
        bf_hold_d   = op_bf_s;
        wr_hold_d   = wreg_sel_s;
        mem_hold_d  = MEM;
        wb_hold_d   = WB;
        out_valid_d = 1'b0;
        mem_d       = {MEM_W{1'b0}};
        wb_d        = {WB_W{1'b0}};
      end else if (accept_s) begin
        out_valid_d = 1'b1;
        result_d    = alu_res_s;
        rd2_d       = op_bf_s;
        zero_d      = (alu_res_s == {XLEN{1'b0}});
        wreg_d      = wreg_sel_s;
        mem_d       = MEM;
        wb_d        = WB;
      end else if (!stall_in) begin
        out_valid_d = 1'b0;
        mem_d       = {MEM_W{1'b0}};
        wb_d        = {WB_W{1'b0}};
      end else begin
        state_d = S_RUN;
      end
    end else begin
      if (cnt_q == CNT_LAST) begin
        if (!stall_in) begin
          // Final step lands directly in the EX/MEM register
          state_d     = S_RUN;
          cnt_d       = {CW{1'b0}};
          out_valid_d = 1'b1;
          result_d    = step_sum_s;
          rd2_d       = bf_hold_q;
          zero_d      = (step_sum_s == {XLEN{1'b0}});
          wreg_d      = wr_hold_q;
          mem_d       = mem_hold_q;
          wb_d        = wb_hold_q;
        end else begin
          state_d = S_MUL;
        end
      end else begin
        acc_d    = step_sum_s;
        mcand_d  = mcand_q << MUL_R;
        mplier_d = mplier_q >> MUL_R;
        cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (!stall_in) begin
          out_valid_d = 1'b0;
          mem_d       = {MEM_W{1'b0}};
          wb_d        = {WB_W{1'b0}};
        end else begin
          out_valid_d = out_valid_q;
        end
      end
    end
  end

  // State, multiplier and EX/MEM register flops with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_RUN;
      cnt_q       <= {CW{1'b0}};
      acc_q       <= {XLEN{1'b0}};
      mcand_q     <= {XLEN{1'b0}};
      mplier_q    <= {XLEN{1'b0}};
      bf_hold_q   <= {XLEN{1'b0}};
      wr_hold_q   <= {REGW{1'b0}};
      mem_hold_q  <= {MEM_W{1'b0}};
      wb_hold_q   <= {WB_W{1'b0}};
      out_valid_q <= 1'b0;
      result_q    <= {XLEN{1'b0}};
      rd2_q       <= {XLEN{1'b0}};
      zero_q      <= 1'b0;
      wreg_q      <= {REGW{1'b0}};
      mem_q       <= {MEM_W{1'b0}};
      wb_q        <= {WB_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      bf_hold_q   <= bf_hold_d;
      wr_hold_q   <= wr_hold_d;
      mem_hold_q  <= mem_hold_d;
      wb_hold_q   <= wb_hold_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      rd2_q       <= rd2_d;
      zero_q      <= zero_d;
      wreg_q      <= wreg_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
    end
  end

  assign out_valid          = out_valid_q;
  assign result_out         = result_q;
  assign read_d2_out        = rd2_q;
  assign zero               = zero_q;
  assign write_register_out = wreg_q;
  assign MEM_out            = mem_q;
  assign WB_out             = wb_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Testbench for ex_stage_pipe: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_ex_stage_pipe;
  localparam int XLEN  = 32;
  localparam int REGW  = 5;
  localparam int MEM_W = 3;
  localparam int WB_W  = 2;
  localparam int MUL_R = 1;
  localparam int N     = XLEN / MUL_R;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, stall_out, stall_in, flush;
  logic [REGW-1:0]  rs, rt, rd, EXMEMRegRd, MEMWBRegRd;
  logic [XLEN-1:0]  read_d1, read_d2, se, ALU_result, WB_data;
  logic             reg_dst, alu_src, EXMEM_RegWrite, MEMWB_RegWrite;
  logic [3:0]       alu_op;
  logic [MEM_W-1:0] MEM, MEM_out;
  logic [WB_W-1:0]  WB, WB_out;
  logic [1:0]       ForwardA, ForwardB;
  logic             out_valid, zero;
  logic [XLEN-1:0]  result_out, read_d2_out;
  logic [REGW-1:0]  write_register_out;

  ex_stage_pipe #(.XLEN(XLEN), .REGW(REGW), .MEM_W(MEM_W), .WB_W(WB_W), .MUL_R(MUL_R)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall_out(stall_out), .stall_in(stall_in),
    .flush(flush), .rs(rs), .rt(rt), .rd(rd), .read_d1(read_d1), .read_d2(read_d2), .se(se),
    .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op), .MEM(MEM), .WB(WB),
    .EXMEMRegRd(EXMEMRegRd), .MEMWBRegRd(MEMWBRegRd), .EXMEM_RegWrite(EXMEM_RegWrite),
    .MEMWB_RegWrite(MEMWB_RegWrite), .ALU_result(ALU_result), .WB_data(WB_data),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .out_valid(out_valid), .result_out(result_out),
    .read_d2_out(read_d2_out), .zero(zero), .write_register_out(write_register_out),
    .MEM_out(MEM_out), .WB_out(WB_out)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: expected EX/MEM contents plus a pending multiply
  logic             m_valid, m_zero;
  logic [XLEN-1:0]  m_res, m_rd2;
  logic [REGW-1:0]  m_wreg;
  logic [MEM_W-1:0] m_mem;
  logic [WB_W-1:0]  m_wb;
  logic             m_busy;
  int               m_rem;
  logic [XLEN-1:0]  p_res, p_rd2;
  logic [REGW-1:0]  p_wreg;
  logic [MEM_W-1:0] p_mem;
  logic [WB_W-1:0]  p_wb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src);
    if (EXMEM_RegWrite && EXMEMRegRd != 0 && EXMEMRegRd == src) return 2'd2;
    if (MEMWB_RegWrite && MEMWBRegRd != 0 && MEMWBRegRd == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [XLEN-1:0] fwd_val(input logic [1:0] sel, input logic [XLEN-1:0] r);
    if (sel == 2'd2) return ALU_result;
    if (sel == 2'd1) return WB_data;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] alu_ref(input logic [3:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd6:  r = a - b;
      4'd3:  r = a << b[4:0];
      4'd4:  r = a >> b[4:0];
      4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: r = ~(a | b);
      4'd8:  r = a * b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic m_bubble();
    m_valid = 1'b0;
    m_mem   = '0;
    m_wb    = '0;
  endtask

  task automatic m_load(input logic [XLEN-1:0] r, input logic [XLEN-1:0] d2,
                        input logic [REGW-1:0] w, input logic [MEM_W-1:0] me,
                        input logic [WB_W-1:0] wb);
    m_valid = 1'b1;
    m_res   = r;
    m_zero  = (r == 0);
    m_rd2   = d2;
    m_wreg  = w;
    m_mem   = me;
    m_wb    = wb;
  endtask

  // Apply one rising edge to the model using the currently driven inputs
  task automatic model_edge();
    logic [XLEN-1:0] a, bf, b;
    logic [REGW-1:0] w;
    a  = fwd_val(fwd_sel(rs), read_d1);
    bf = fwd_val(fwd_sel(rt), read_d2);
    b  = alu_src ? se : bf;
    w  = reg_dst ? rd : rt;
    if (!rst) begin
      m_valid = 0; m_zero = 0; m_res = 0; m_rd2 = 0; m_wreg = 0; m_mem = 0; m_wb = 0;
      m_busy = 0; m_rem = 0;
    end else if (flush) begin
      m_busy = 0; m_rem = 0;
      m_bubble();
    end else if (m_busy) begin
      if (m_rem > 1) begin
        m_rem--;
        if (!stall_in) m_bubble();
      end else if (!stall_in) begin
        m_load(p_res, p_rd2, p_wreg, p_mem, p_wb);
        m_busy = 0; m_rem = 0;
      end
    end else if (in_valid && !stall_in) begin
      if (alu_op == 4'd8) begin
        m_busy = 1; m_rem = N;
        p_res = a * b; p_rd2 = bf; p_wreg = w; p_mem = MEM; p_wb = WB;
        m_bubble();
      end else begin
        m_load(alu_ref(alu_op, a, b), bf, w, MEM, WB);
      end
    end else if (!stall_in) begin
      m_bubble();
    end
  endtask

  // One clock cycle: inputs already driven after the falling edge
  task automatic step();
    #1;
    chk("fwdA", ForwardA, fwd_sel(rs));
    chk("fwdB", ForwardB, fwd_sel(rt));
    chk("stall_out", stall_out, m_busy);
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("result_out", result_out, m_res);
    chk("read_d2_out", read_d2_out, m_rd2);
    chk("zero", zero, m_zero);
    chk("wreg", write_register_out, m_wreg);
    chk("MEM_out", MEM_out, m_mem);
    chk("WB_out", WB_out, m_wb);
    @(negedge clk);
  endtask

  task automatic set_op(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    in_valid = 1'b1; alu_op = op; read_d1 = a; read_d2 = b; alu_src = 1'b0; se = '0;
    rs = 5'd1; rt = 5'd2; rd = 5'd4; reg_dst = 1'b1; MEM = 3'b101; WB = 2'b11;
    EXMEM_RegWrite = 1'b0; MEMWB_RegWrite = 1'b0; flush = 1'b0; stall_in = 1'b0;
  endtask

  int cnt;
  logic [3:0] ops [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd12, 4'd8, 4'd5, 4'd15};

  initial begin
    rst = 1'b0; in_valid = 0; stall_in = 0; flush = 0; rs = 0; rt = 0; rd = 0;
    read_d1 = 0; read_d2 = 0; se = 0; reg_dst = 0; alu_src = 0; alu_op = 0; MEM = 0; WB = 0;
    EXMEMRegRd = 0; MEMWBRegRd = 0; EXMEM_RegWrite = 0; MEMWB_RegWrite = 0;
    ALU_result = 0; WB_data = 0;
    m_busy = 0; m_rem = 0;
    @(negedge clk);
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_result", result_out, 0);
    chk("rst_stall", stall_out, 0);
    rst = 1'b1;

    // Single-cycle operations
    set_op(4'd2, 32'd7, 32'hFFFF_FFFD); step();
    chk("add_res", result_out, 32'd4); chk("add_zero", zero, 0); chk("add_valid", out_valid, 1);
    set_op(4'd6, 32'd5, 32'd5); step();
    chk("sub_res", result_out, 32'd0); chk("sub_zero", zero, 1);
    set_op(4'd7, 32'hFFFF_FFFF, 32'd1); step();
    chk("slt_res", result_out, 32'd1);
    set_op(4'd4, 32'h8000_0000, 32'd0); alu_src = 1'b1; se = 32'd31; step();
    chk("srl_res", result_out, 32'd1);

    // Bubble keeps data, clears valid and control bundles
    in_valid = 1'b0; step();
    chk("bub_valid", out_valid, 0); chk("bub_mem", MEM_out, 0); chk("bub_wb", WB_out, 0);
    chk("bub_hold", result_out, 32'd1);

    // Forwarding priority and register 0
    set_op(4'd2, 32'd0, 32'd5); rs = 5'd3; EXMEMRegRd = 5'd3; MEMWBRegRd = 5'd3;
    EXMEM_RegWrite = 1'b1; MEMWB_RegWrite = 1'b1; ALU_result = 32'd100; WB_data = 32'd200;
    #1 chk("fwd_pri", ForwardA, 2'd2);
    step();
    chk("fwd_res", result_out, 32'd105);
    rs = 5'd0; EXMEMRegRd = 5'd0; MEMWBRegRd = 5'd0;
    #1 chk("fwd_r0", ForwardA, 2'd0);
    step();

    // Multiply latency
    set_op(4'd8, 32'h0000_FFFF, 32'h0001_0001); step();
    cnt = 0;
    while (stall_out && cnt < 100) begin cnt++; step(); end
    chk("mul_lat", cnt, N);
    chk("mul_res", result_out, 32'hFFFF_FFFF); chk("mul_valid", out_valid, 1);

    // Stall held over the final multiply step, then back-to-back ADD
    set_op(4'd8, 32'd6, 32'd7); step();
    for (int k = 1; k < N; k++) step();
    stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); chk("stl_valid", out_valid, 0); chk("stl_busy", stall_out, 1);
    end
    stall_in = 1'b0; step();
    chk("stl_res", result_out, 32'd42); chk("stl_done", stall_out, 0);
    set_op(4'd2, 32'd1, 32'd2); step();
    chk("b2b_res", result_out, 32'd3); chk("b2b_valid", out_valid, 1);

    // Flush mid multiply
    set_op(4'd8, 32'd9, 32'd9); step();
    for (int k = 0; k < 4; k++) step();
    flush = 1'b1; step();
    chk("fl_valid", out_valid, 0); chk("fl_stall", stall_out, 0);
    set_op(4'd2, 32'd10, 32'd20); step();
    chk("fl_add", result_out, 32'd30);

    // Reset mid multiply
    set_op(4'd8, 32'd3, 32'd3); step();
    for (int k = 0; k < 3; k++) step();
    rst = 1'b0; step();
    chk("rm_valid", out_valid, 0); chk("rm_res", result_out, 0); chk("rm_stall", stall_out, 0);
    chk("rm_wreg", write_register_out, 0);
    rst = 1'b1;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 499) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      stall_in = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      alu_op   = ($urandom_range(0, 11) == 0) ? 4'd8 : ops[$urandom_range(0, 10)];
      if (alu_op == 4'd8 && $urandom_range(0, 2) != 0) alu_op = 4'd2;
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 31));
      EXMEMRegRd = 5'($urandom_range(0, 3)); MEMWBRegRd = 5'($urandom_range(0, 3));
      EXMEM_RegWrite = 1'($urandom_range(0, 1)); MEMWB_RegWrite = 1'($urandom_range(0, 1));
      read_d1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : 32'($urandom);
      read_d2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : 32'($urandom);
      se = 32'($urandom); ALU_result = 32'($urandom); WB_data = 32'($urandom);
      reg_dst = 1'($urandom_range(0, 1)); alu_src = 1'($urandom_range(0, 1));
      MEM = 3'($urandom_range(0, 7)); WB = 2'($urandom_range(0, 3));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
